// File: rtl/sid.sv
// Shared SID constants and the schedule output bundle for sid_pipe_sched.
// SID_PIPE_SID2_EN selects the dual-SID schedule; otherwise only SID0 runs.
package sid;

    localparam logic [4:0] SCHED_VOICE_FIRST   = 5'd1;
    localparam logic [4:0] SCHED_FILTER0_FIRST = 5'd5;
    localparam logic [4:0] SCHED_FILTER1_FIRST = 5'd13;
`ifdef SID_PIPE_SID2_EN
    localparam logic [4:0] SCHED_LAST = 5'd21;
`else
    localparam logic [4:0] SCHED_LAST = 5'd13;
`endif

    typedef struct packed {
        logic       busy;
        logic       voice_active;
        logic       voice_sid;
        logic [1:0] voice_no;
        logic       capture_valid;
        logic       capture_sid;
        logic [1:0] capture_no;
        logic [1:0] osc3_load;
        logic [1:0] filter_load;
        logic [2:0] filter_stage;
        logic       filter_no;
        logic [1:0] audio_done;
    } sched_t;

endpackage

// File: rtl/sid_pipe_sched.sv
// Cycle scheduler sharing one voice and one filter pipeline across the SIDs.
// Build option SID_PIPE_SID2_EN enables the second SID; default is SID0 only.
module sid_pipe_sched
    import sid::*;
#(
    parameter int FILTER_LEN = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic       busy,
    output logic       overrun,
    output logic       voice_active,
    output logic       voice_sid,
    output logic [1:0] voice_no,
    output logic       capture_valid,
    output logic       capture_sid,
    output logic [1:0] capture_no,
    output logic [1:0] osc3_load,
    output logic [1:0] filter_load,
    output logic [2:0] filter_stage,
    output logic       filter_no,
    output logic [1:0] audio_done
);

    localparam logic [4:0] FLEN     = 5'(FILTER_LEN);
    localparam logic [4:0] OSC0_T   = SCHED_VOICE_FIRST + 5'd3;
    localparam logic [4:0] DONE0_T  = SCHED_FILTER0_FIRST + FLEN;
    // Pass 0 only samples filter_i in stages 0..3, so SID1 may reload after that.
    localparam logic [4:0] FLOAD1_T = SCHED_FILTER0_FIRST + 5'd4;
    localparam logic [4:0] OSC1_T   = SCHED_VOICE_FIRST + 5'd6;
    localparam logic [4:0] DONE1_T  = SCHED_FILTER1_FIRST + FLEN;

    logic [4:0] t_p0;
    logic [4:0] t_nxt;
    sched_t     sched_nxt;
    sched_t     sched_p0;
    logic       overrun_p0;

    // Slot k of the voice feed -> {active, sid, voice number}.
    function automatic logic [3:0] voice_slot(input logic [4:0] k);
        logic [3:0] r;
        r = '0;
        if (k >= 5'd1 && k <= 5'd3)
            r = {1'b1, 1'b0, 2'(k)};
`ifdef SID_PIPE_SID2_EN
        else if (k >= 5'd4 && k <= 5'd6)
            r = {1'b1, 1'b1, 2'(k - 5'd3)};
`endif
        return r;
    endfunction

    function automatic sched_t decode(input logic [4:0] tt);
        sched_t s;
        s = '0;
        s.busy = (tt != 5'd0);
        {s.voice_active, s.voice_sid, s.voice_no} =
            voice_slot(tt - SCHED_VOICE_FIRST + 5'd1);
        {s.capture_valid, s.capture_sid, s.capture_no} =
            voice_slot(tt - SCHED_VOICE_FIRST);
        s.osc3_load[0]   = (tt == OSC0_T);
        s.filter_load[0] = (tt == OSC0_T);
        if (tt >= SCHED_FILTER0_FIRST && tt < DONE0_T)
            s.filter_stage = 3'(tt - SCHED_FILTER0_FIRST);
`ifdef SID_PIPE_SID2_EN
        s.osc3_load[1]   = (tt == OSC1_T);
        s.filter_load[1] = (tt == FLOAD1_T);
        if (tt >= SCHED_FILTER1_FIRST && tt < DONE1_T) begin
            s.filter_stage = 3'(tt - SCHED_FILTER1_FIRST);
            s.filter_no    = 1'b1;
        end
        s.audio_done[0] = (tt == DONE0_T);
        s.audio_done[1] = (tt == DONE1_T);
`else
        s.audio_done = (tt == DONE0_T) ? 2'b11 : 2'b00;
`endif
        return s;
    endfunction

    always_comb begin
        t_nxt = t_p0;
        if (t_p0 == 5'd0) begin
            if (start)
                t_nxt = SCHED_VOICE_FIRST;
        end else if (t_p0 == SCHED_LAST) begin
            t_nxt = 5'd0;
        end else begin
            t_nxt = t_p0 + 5'd1;
        end
        sched_nxt = decode(t_nxt);
    end

    // Stage p0: counter and decoded outputs registered together so they stay aligned.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            t_p0       <= 5'd0;
            sched_p0   <= '0;
            overrun_p0 <= 1'b0;
        end else begin
            t_p0       <= t_nxt;
            sched_p0   <= sched_nxt;
            overrun_p0 <= start && (t_p0 != 5'd0);
        end
    end

    assign busy          = sched_p0.busy;
    assign overrun       = overrun_p0;
    assign voice_active  = sched_p0.voice_active;
    assign voice_sid     = sched_p0.voice_sid;
    assign voice_no      = sched_p0.voice_no;
    assign capture_valid = sched_p0.capture_valid;
    assign capture_sid   = sched_p0.capture_sid;
    assign capture_no    = sched_p0.capture_no;
    assign osc3_load     = sched_p0.osc3_load;
    assign filter_load   = sched_p0.filter_load;
    assign filter_stage  = sched_p0.filter_stage;
    assign filter_no     = sched_p0.filter_no;
    assign audio_done    = sched_p0.audio_done;

endmodule
